// File: rtl/dlx_fetch_stage.sv
// dlx_fetch_stage: DLX instruction fetch with IF/ID pipeline register.
// Holds the PC and issues word fetches over a req/ready handshake. Redirects
// to branch/jump targets. Stalls are absorbed by a one-entry skid buffer.
// Build option: define DLX_DELAY_SLOT_EN for an architectural branch delay slot.
// With it defined, a redirect does not flush IF/ID, and the response still in
// flight at redirect time is delivered. Without it, old-path instructions are
// flushed on redirect.
module dlx_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] ifid_ins,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend_target, pend_n;
    logic [31:0] skid_ins, skid_ins_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic [31:0] ins_n, pc4_n;
    logic        vld_n;
    // High for the single cycle after reset release; keeps the request low.
    logic        boot;

    logic        complete;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;

    // The request is raised in FETCH and DRAIN. It drops only in HOLD, and HOLD
    // is entered only on a completing cycle, so a request is never withdrawn.
    assign imem_req  = !boot && (state != S_HOLD);
    // The PC is always word aligned, so the low address bits are zero.
    assign imem_addr = pc;
    assign complete  = imem_req && imem_ready;
    assign pc_plus4  = pc + 32'd4;
    assign tgt       = redirect_target & ~32'd3;

    // Next-state logic: the base behaviour first, then the redirect overlay.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pend_n     = pend_target;
        ins_n      = ifid_ins;
        pc4_n      = ifid_pc4;
        vld_n      = ifid_valid;
        skid_ins_n = skid_ins;
        skid_pc4_n = skid_pc4;

        case (state)
            S_FETCH: begin
                if (complete) begin
                    pc_n = pc_plus4;
                    if (stall) begin
                        skid_ins_n = imem_data;
                        skid_pc4_n = pc_plus4;
                        state_n    = S_HOLD;
                    end else begin
                        ins_n = imem_data;
                        pc4_n = pc_plus4;
                        vld_n = 1'b1;
                    end
                end else if (!stall) begin
                    ins_n = BUBBLE_INS;
                    vld_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    ins_n   = skid_ins;
                    pc4_n   = skid_pc4;
                    vld_n   = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_DRAIN: begin
`ifdef DLX_DELAY_SLOT_EN
                // The drained response is the delay-slot instruction.
                if (complete) begin
                    pc_n = pend_target;
                    if (stall) begin
                        skid_ins_n = imem_data;
                        skid_pc4_n = pc_plus4;
                        state_n    = S_HOLD;
                    end else begin
                        ins_n   = imem_data;
                        pc4_n   = pc_plus4;
                        vld_n   = 1'b1;
                        state_n = S_FETCH;
                    end
                end else if (!stall) begin
                    ins_n = BUBBLE_INS;
                    vld_n = 1'b0;
                end
`else
                // The drained response is wrong-path and is dropped.
                if (complete) begin
                    pc_n    = pend_target;
                    state_n = S_FETCH;
                end
                if (!stall) begin
                    ins_n = BUBBLE_INS;
                    vld_n = 1'b0;
                end
`endif
            end
            default: state_n = S_FETCH;
        endcase

        if (redirect_valid) begin
`ifdef DLX_DELAY_SLOT_EN
            // The delay slot leaves IF/ID and the skid untouched.
`else
            ins_n = BUBBLE_INS;
            vld_n = 1'b0;
`endif
            case (state)
                S_FETCH: begin
                    // Nothing is outstanding during boot, so jump straight there.
                    if (complete || boot) begin
                        pc_n = tgt;
`ifdef DLX_DELAY_SLOT_EN
`else
                        state_n = S_FETCH;
`endif
                    end else begin
                        pend_n  = tgt;
                        state_n = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    pc_n = tgt;
`ifdef DLX_DELAY_SLOT_EN
`else
                    state_n = S_FETCH;
`endif
                end
                S_DRAIN: begin
                    // The latest redirect wins.
                    if (complete) pc_n = tgt;
                    else          pend_n = tgt;
                end
                default: ;
            endcase
        end
    end

    // State registers: asynchronous reset, rising-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pend_target <= '0;
            boot        <= 1'b1;
            skid_ins    <= '0;
            skid_pc4    <= '0;
            ifid_ins    <= BUBBLE_INS;
            ifid_pc4    <= '0;
            ifid_valid  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_target <= pend_n;
            boot        <= 1'b0;
            skid_ins    <= skid_ins_n;
            skid_pc4    <= skid_pc4_n;
            ifid_ins    <= ins_n;
            ifid_pc4    <= pc4_n;
            ifid_valid  <= vld_n;
        end
    end

endmodule
